// File: rtl/program_loader.sv
// Byte-stream program loader: parses a 16-bit little-endian word count, then
// assembles little-endian 32-bit words and writes them to consecutive word addresses.
module program_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [31:0]           o_mem_din,
    output logic [ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [1:0]            o_mem_size,
    output logic                  o_mem_wen,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [1:0]            o_error_code,
    output logic [15:0]           o_word_count,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERROR
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // The timeout fires on the edge where the idle counter would reach TIMEOUT_CYCLES-1.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [63:0]   CAP        = ((64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR)) >> 2;

    state_t                  state, state_next;
    logic [TW-1:0]           timer;
    logic [1:0]              lane;
    logic [23:0]             asm_word;
    logic [7:0]              len_lo;
    logic [15:0]             n_words;
    logic [ADDR_WIDTH-1:0]   ptr;

    logic                    load, write_word, timeout, oversize, busy, timer_hit;
    logic [15:0]             header;

    assign header      = {i_rx_data, len_lo};
    assign timer_hit   = (timer == TIMER_LAST);
    assign busy        = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA);
    assign o_busy      = busy;
    assign o_done      = (state == S_DONE);
    assign o_error     = (state == S_ERROR);
    assign o_mem_size  = 2'b11;
    assign o_dbg_state = state;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        write_word = 1'b0;
        timeout    = 1'b0;
        oversize   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    state_next = S_LEN_LO;
                    load       = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (i_rx_valid) begin
                    state_next = S_LEN_HI;
                end else if (timer_hit) begin
                    state_next = S_ERROR;
                    timeout    = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (i_rx_valid) begin
                    if (header == 16'd0) begin
                        state_next = S_DONE;
                    end else if (64'(header) > CAP) begin
                        state_next = S_ERROR;
                        oversize   = 1'b1;
                    end else begin
                        state_next = S_DATA;
                    end
                end else if (timer_hit) begin
                    state_next = S_ERROR;
                    timeout    = 1'b1;
                end
            end
            S_DATA: begin
                if (i_rx_valid) begin
                    if (lane == 2'd3) begin
                        write_word = 1'b1;
                        if (o_word_count + 16'd1 == n_words) state_next = S_DONE;
                    end
                end else if (timer_hit) begin
                    state_next = S_ERROR;
                    timeout    = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            timer        <= '0;
            lane         <= 2'd0;
            asm_word     <= 24'd0;
            len_lo       <= 8'd0;
            n_words      <= 16'd0;
            ptr          <= '0;
            o_mem_din    <= 32'd0;
            o_mem_waddr  <= '0;
            o_mem_wen    <= 1'b0;
            o_error_code <= 2'b00;
            o_word_count <= 16'd0;
        end else begin
            state     <= state_next;
            o_mem_wen <= write_word;

            if (load) begin
                timer        <= '0;
                lane         <= 2'd0;
                o_word_count <= 16'd0;
                o_error_code <= 2'b00;
                ptr          <= ADDR_WIDTH'(BASE_ADDR);
            end else if (busy) begin
                timer <= i_rx_valid ? '0 : timer + TW'(1);
            end

            if (state == S_LEN_LO && i_rx_valid) len_lo <= i_rx_data;
            if (state == S_LEN_HI && i_rx_valid) n_words <= header;

            // Lanes 0-2 are buffered; lane 3 completes the word straight into the output register.
            if (state == S_DATA && i_rx_valid) begin
                lane <= lane + 2'd1;
                case (lane)
                    2'd0: asm_word[7:0]   <= i_rx_data;
                    2'd1: asm_word[15:8]  <= i_rx_data;
                    2'd2: asm_word[23:16] <= i_rx_data;
                    default: begin
                        o_mem_din    <= {i_rx_data, asm_word};
                        o_mem_waddr  <= ptr;
                        ptr          <= ptr + ADDR_WIDTH'(4);
                        o_word_count <= o_word_count + 16'd1;
                    end
                endcase
            end

            if (oversize) o_error_code <= 2'b01;
            if (timeout)  o_error_code <= 2'b10;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader (ADDR_WIDTH=10, BASE_ADDR=0, TIMEOUT_CYCLES=16).
module tb_program_loader;

    localparam int AW   = 10;
    localparam int BASE = 0;
    localparam int TO   = 16;
    localparam int W    = 59;  // {done, word_count[15:0], waddr[9:0], data[31:0]}

    logic          clk = 1'b0;
    logic          i_rst_n, i_start, i_rx_valid;
    logic [7:0]    i_rx_data;
    logic [31:0]   o_mem_din;
    logic [AW-1:0] o_mem_waddr;
    logic [1:0]    o_mem_size, o_error_code;
    logic          o_mem_wen, o_busy, o_done, o_error;
    logic [15:0]   o_word_count;
    logic [2:0]    o_dbg_state;

    logic [W-1:0]  exp_q[$];
    int            wen_cyc[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid), .o_mem_din(o_mem_din), .o_mem_waddr(o_mem_waddr),
        .o_mem_size(o_mem_size), .o_mem_wen(o_mem_wen), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_error_code(o_error_code), .o_word_count(o_word_count),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // monitor: every write strobe must match the head of the expected queue
    logic [W-1:0] e;
    always @(negedge clk) begin
        if (o_mem_wen === 1'b1) begin
            wen_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_write", o_mem_waddr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("mem_din", o_mem_din, e[31:0]);
                check("mem_waddr", o_mem_waddr, e[41:32]);
                check("word_count_at_write", o_word_count, e[57:42]);
                check("done_at_write", o_done, e[58]);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        step();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("busy_after_start", o_busy, 1);
        check("code_cleared", o_error_code, 0);
        check("count_cleared", o_word_count, 0);
    endtask

    task automatic send_hdr(input logic [15:0] n, input int lo, input int hi);
        send_byte(n[7:0]);
        idle($urandom_range(lo, hi));
        send_byte(n[15:8]);
        idle($urandom_range(lo, hi));
    endtask

    task automatic send_word(input logic [31:0] w, input int lo, input int hi);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            idle($urandom_range(lo, hi));
        end
    endtask

    task automatic expect_write(input int idx, input int n, input logic [31:0] w);
        exp_q.push_back({(idx == n - 1), 16'(idx + 1), AW'(BASE + 4 * idx), w});
    endtask

    task automatic run_load(input int n, input int lo, input int hi);
        logic [31:0] w;
        start_pulse();
        send_hdr(16'(n), lo, hi);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            expect_write(i, n, w);
            send_word(w, lo, hi);
        end
        step();
        check("load_queue_drained", exp_q.size(), 0);
        check("load_done", o_done, 1);
        check("load_busy", o_busy, 0);
        check("load_word_count", o_word_count, n);
    endtask

    task automatic check_reset_values();
        check("rst_din", o_mem_din, 0);
        check("rst_waddr", o_mem_waddr, 0);
        check("rst_wen", o_mem_wen, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_code", o_error_code, 0);
        check("rst_count", o_word_count, 0);
        check("mem_size", o_mem_size, 3);
    endtask

    initial begin
        logic [7:0] b[4];
        i_rst_n = 1'b0; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
        idle(3);
        check_reset_values();
        i_rst_n = 1'b1;
        idle(2);

        // fixed two-word load, one byte every 3 cycles
        start_pulse();
        send_byte(8'h02); idle(2); send_byte(8'h00); idle(2);
        exp_q.push_back({1'b0, 16'd1, 10'h000, 32'h12345678});
        send_word(32'h12345678, 2, 2);
        exp_q.push_back({1'b1, 16'd2, 10'h004, 32'hDEADBEEF});
        send_word(32'hDEADBEEF, 2, 2);
        check("fixed_queue_drained", exp_q.size(), 0);
        check("fixed_done", o_done, 1);
        check("fixed_count", o_word_count, 2);

        // back-to-back bytes, N=3: strobes exactly 4 cycles apart
        wen_cyc.delete();
        run_load(3, 0, 0);
        check("b2b_strobes", wen_cyc.size(), 3);
        if (wen_cyc.size() == 3) begin
            check("b2b_gap0", wen_cyc[1] - wen_cyc[0], 4);
            check("b2b_gap1", wen_cyc[2] - wen_cyc[1], 4);
        end

        // zero length
        start_pulse();
        send_byte(8'h00); send_byte(8'h00);
        check("zero_done", o_done, 1);
        check("zero_busy", o_busy, 0);
        check("zero_count", o_word_count, 0);

        // oversize: 257 words > capacity 256
        start_pulse();
        send_byte(8'h01); send_byte(8'h01);
        check("over_error", o_error, 1);
        check("over_code", o_error_code, 1);
        check("over_busy", o_busy, 0);
        idle(3);
        run_load($urandom_range(1, 4), 0, 2);

        // exactly full capacity
        run_load(256, 0, 0);

        // timeout: error exactly 15 cycles after the last byte
        start_pulse();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        idle(14);
        check("to_not_yet_error", o_error, 0);
        check("to_not_yet_busy", o_busy, 1);
        step();
        check("to_error", o_error, 1);
        check("to_code", o_error_code, 2);
        check("to_count", o_word_count, 0);
        idle(3);

        // a byte on the expiry cycle keeps the load alive
        start_pulse();
        send_byte(8'h01); send_byte(8'h00);
        for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
        send_byte(b[0]); send_byte(b[1]);
        idle(14);
        send_byte(b[2]);
        check("expiry_byte_busy", o_busy, 1);
        check("expiry_byte_error", o_error, 0);
        exp_q.push_back({1'b1, 16'd1, 10'h000, b[3], b[2], b[1], b[0]});
        send_byte(b[3]);
        step();
        check("expiry_queue_drained", exp_q.size(), 0);
        check("expiry_done", o_done, 1);

        // abort: mid-load start ignored, then reset after 5 data bytes
        start_pulse();
        send_byte(8'h03); send_byte(8'h00);
        for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
        send_byte(b[0]); send_byte(b[1]);
        i_start = 1'b1; step(); i_start = 1'b0;
        check("midstart_busy", o_busy, 1);
        check("midstart_state_data", o_error | o_done, 0);
        exp_q.push_back({1'b0, 16'd1, 10'h000, b[3], b[2], b[1], b[0]});
        send_byte(b[2]); send_byte(b[3]);
        send_byte(8'($urandom));
        check("abort_count", o_word_count, 1);
        i_rst_n = 1'b0;
        step();
        check_reset_values();
        i_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_rx_data  = 8'($urandom);
            i_rx_valid = 1'($urandom_range(0, 1));
            step();
        end
        i_rx_valid = 1'b0;
        check("abort_idle_busy", o_busy, 0);
        check("abort_queue_drained", exp_q.size(), 0);
        run_load(2, 0, 1);

        // randomized loads
        for (int r = 0; r < 6; r++) run_load($urandom_range(1, 6), 0, 3);

        idle(4);
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream feeder of the CPU's byte-banked instruction/data memory write port. Receives a byte stream (from the UART receiver of the debug unit), parses a 16-bit little-endian word-count header, assembles the following bytes into little-endian 32-bit words, and issues one word-sized write per assembled word at consecutive word addresses starting at `BASE_ADDR`. It reports busy, done, and error status to the debug unit, and enforces memory capacity and inter-byte timeout.

## Interface

Parameters:
- `ADDR_WIDTH`, 10: byte address width of the target memory.
- `BASE_ADDR`, 0: byte address of the first word written. Must be a multiple of 4.
- `TIMEOUT_CYCLES`, 1000000: maximum idle cycles allowed between accepted bytes while loading.

Ports:
- `clk`  in  1  clock; one clock domain.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_start`  in  1  load command pulse. Honoured only in IDLE, DONE or ERROR.
- `i_rx_data`  in  8  received byte.
- `i_rx_valid`  in  1  `i_rx_data` valid this cycle. Single-cycle strobe per byte.
- `o_mem_din`  out  32  assembled word, with byte 0 = first received byte at bits [7:0].
- `o_mem_waddr`  out  ADDR_WIDTH  byte address of the write.
- `o_mem_size`  out  2  constant 2'b11 (word write).
- `o_mem_wen`  out  1  one-cycle write strobe.
- `o_busy`  out  1  high in LEN_LO, LEN_HI, DATA.
- `o_done`  out  1  high in DONE.
- `o_error`  out  1  high in ERROR.
- `o_error_code`  out  2  01 = length exceeds capacity; 10 = timeout; 00 otherwise.
- `o_word_count`  out  16  words written since last accepted `i_start`.

## Operation

- States: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR.
- IDLE/DONE/ERROR + `i_start` → LEN_LO:
  - clear `o_word_count`, `o_error_code`, byte index, timeout counter;
  - set write pointer to `BASE_ADDR`.
- Bytes with `i_rx_valid` in IDLE/DONE/ERROR are ignored. `i_start` in busy states is ignored.
- LEN_LO: a valid byte becomes N[7:0] → LEN_HI.
- LEN_HI: a valid byte becomes N[15:8]. Then:
  - N == 0 → DONE;
  - N > CAP → ERROR with code 01, where CAP = (2^ADDR_WIDTH − BASE_ADDR)/4 words;
  - otherwise → DATA.
- DATA: each valid byte goes into byte lane [index] of the assembly register, and the index increments mod 4. On lane 3:
  - register the word to `o_mem_din` and the pointer to `o_mem_waddr`;
  - pulse `o_mem_wen`;
  - increment `o_word_count`;
  - advance the pointer by 4.
  - If this was word N, go to DONE; otherwise stay in DATA.
- Addresses never wrap, because the capacity check precedes any write. Pointer arithmetic is ADDR_WIDTH bits wide.
- Timeout:
  - The counter runs in LEN_LO, LEN_HI and DATA, and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES−1 without a byte → ERROR with code 10. Any partial word is discarded and never written.
  - A byte arriving in the same cycle the counter expires is accepted, and the timeout does not fire.
- ERROR and DONE hold until `i_start` or reset.

## Timing

- Reset (`i_rst_n` = 0 at a clk edge) values:
  - state IDLE;
  - `o_mem_din` = 0, `o_mem_waddr` = 0, `o_mem_wen` = 0;
  - `o_busy` = `o_done` = `o_error` = 0;
  - `o_error_code` = 0, `o_word_count` = 0.
  - `o_mem_size` is always 2'b11.
- Reset during a load aborts it immediately. No further writes occur, and the partial word is dropped.
- `i_start` sampled at edge t → `o_busy` = 1 from t+1.
- The 4th byte of a word sampled at edge t:
  - `o_mem_wen` = 1 during cycle t+1 only, with `o_mem_din`/`o_mem_waddr` valid in that cycle;
  - `o_word_count` is updated at t+1.
- Last word: `o_done` = 1 and `o_busy` = 0 from t+1, in the same cycle as the final `o_mem_wen`.
- The length header byte sampled at t yields DONE/ERROR/DATA at t+1.
- Bytes may arrive every cycle. A byte arriving in a cycle where `o_mem_wen` is high is accepted normally, so there is no backpressure and no lost bytes.
- `o_mem_din`/`o_mem_waddr` hold their last values between strobes.

## Test plan

- Load 2 words: `i_start`, then bytes 02 00 | 78 56 34 12 | EF BE AD DE, one every 3 cycles. Required response:
  - writes 0x12345678 at 0x000, then 0xDEADBEEF at 0x004;
  - `o_word_count` = 2;
  - `o_done` = 1 in the cycle of the second `o_mem_wen`.
- Back-to-back bytes, one every cycle, with N = 3: three `o_mem_wen` pulses exactly 4 cycles apart at addresses 0x000, 0x004, 0x008, and no dropped bytes.
- Zero length (header 00 00): DONE at the cycle after the second byte, with no `o_mem_wen` pulses.
- Oversize (ADDR_WIDTH = 10, BASE_ADDR = 0, header 01 01, N = 257 > 256): ERROR with `o_error_code` = 01 and no writes. A following `i_start` plus a valid load succeeds.
- Timeout (TIMEOUT_CYCLES = 16): after the header 01 00 and 2 data bytes, stop sending. ERROR with code 10 must follow exactly 15 cycles after the last byte, with no `o_mem_wen`. Sending a byte on that expiry cycle instead keeps the loader in DATA.
- Abort cases:
  - `i_start` pulses mid-load are ignored;
  - asserting `i_rst_n` = 0 after 5 data bytes returns all outputs to reset values with no further writes;
  - a subsequent full load writes from `BASE_ADDR`.
